// File: rtl/pudding_chain_driver.sv
`default_nettype none
// ============================================================================
// Module : pudding_chain_driver
// Brief  : Master-side pin sequencer for the PUDDING serial config chain.
//          WRITE shifts a word in and commits it, READ captures and shifts out.
// Rev    : 1.0  initial release
// ============================================================================
module pudding_chain_driver #(
    parameter  int CHAIN_LEN = 128,
    localparam int CNT_W     = $clog2(CHAIN_LEN) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_read,
    input  logic [CHAIN_LEN-1:0] wr_data,
    output logic [CHAIN_LEN-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 chain_datum,
    output logic                 chain_shift,
    output logic                 chain_transfer,
    output logic                 chain_dir,
    input  logic                 chain_q
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_WSHIFT = 3'd1;
    localparam logic [2:0] c_ST_WXFER  = 3'd2;
    localparam logic [2:0] c_ST_RCAP   = 3'd3;
    localparam logic [2:0] c_ST_RSHIFT = 3'd4;
    localparam logic [2:0] c_ST_RDONE  = 3'd5;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CHAIN_LEN-1:0] r_shreg;
    logic [CHAIN_LEN-1:0] r_rd_data;
    logic                 r_rd_valid;
    logic                 r_datum;
    logic                 r_shift;
    logic                 r_xfer;
    logic                 r_dir;

    logic [2:0]           w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CHAIN_LEN-1:0] w_shreg_nxt;
    logic [CHAIN_LEN-1:0] w_rd_data_nxt;
    logic                 w_rd_valid_nxt;
    logic                 w_datum_nxt;
    logic                 w_shift_nxt;
    logic                 w_xfer_nxt;
    logic                 w_dir_nxt;
    logic                 w_cnt_last;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_datum    <= 1'b0;
            r_shift    <= 1'b0;
            r_xfer     <= 1'b0;
            r_dir      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shreg    <= w_shreg_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_datum    <= w_datum_nxt;
            r_shift    <= w_shift_nxt;
            r_xfer     <= w_xfer_nxt;
            r_dir      <= w_dir_nxt;
        end
    end

    // Pin values are computed for the state being entered, so every pin is a
    // flop output and stays valid for one full cycle at the chain.
    // One shift register serves both directions: write data leaves from the
    // MSB, read data enters at the LSB from chain_q.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = '0;
        w_shreg_nxt    = r_shreg;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;
        w_datum_nxt    = 1'b0;
        w_shift_nxt    = 1'b0;
        w_xfer_nxt     = 1'b0;
        w_dir_nxt      = r_dir;
        case (r_state)
            c_ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_read) begin
                        w_state_nxt = c_ST_RCAP;
                        w_xfer_nxt  = 1'b1;
                        w_dir_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = c_ST_WSHIFT;
                        w_shift_nxt = 1'b1;
                        w_datum_nxt = wr_data[CHAIN_LEN-1];
                        w_shreg_nxt = {wr_data[CHAIN_LEN-2:0], 1'b0};
                    end
                end
            end
            c_ST_WSHIFT: begin
                if (w_cnt_last) begin
                    w_state_nxt = c_ST_WXFER;
                    w_xfer_nxt  = 1'b1;
                    w_dir_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    w_shift_nxt = 1'b1;
                    w_datum_nxt = r_shreg[CHAIN_LEN-1];
                    w_shreg_nxt = {r_shreg[CHAIN_LEN-2:0], 1'b0};
                end
            end
            c_ST_WXFER: begin
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_RCAP: begin
                w_state_nxt = c_ST_RSHIFT;
                w_shift_nxt = 1'b1;
            end
            c_ST_RSHIFT: begin
                // chain_q still shows the pre-shift MSB at this edge
                w_shreg_nxt = {r_shreg[CHAIN_LEN-2:0], chain_q};
                if (w_cnt_last) begin
                    w_state_nxt    = c_ST_RDONE;
                    w_rd_data_nxt  = {r_shreg[CHAIN_LEN-2:0], chain_q};
                    w_rd_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    w_shift_nxt = 1'b1;
                end
            end
            c_ST_RDONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign cmd_ready      = (r_state == c_ST_IDLE);
    assign busy           = ~cmd_ready;
    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign chain_datum    = r_datum;
    assign chain_shift    = r_shift;
    assign chain_transfer = r_xfer;
    assign chain_dir      = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_pudding_chain_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_pudding_chain_driver
// Brief  : Bench for pudding_chain_driver with behavioural chains and a
//          per-cycle pin-sequence model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pudding_chain_driver;

    localparam int CHAIN_LEN = 128;
    localparam int SMALL_LEN = 8;
    localparam logic [CHAIN_LEN-1:0] c_T2_WORD = {8'hA5, 119'd0, 1'b1};
    localparam logic [CHAIN_LEN-1:0] c_T3_WORD = 128'hDEADBEEF_0123_4567_89AB_CDEF_F0E1_D2C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 cmd_valid, cmd_ready, cmd_read;
    logic [CHAIN_LEN-1:0] wr_data, rd_data;
    logic                 rd_valid, busy;
    logic                 chain_datum, chain_shift, chain_transfer, chain_dir, chain_q;

    logic                 s_valid, s_ready, s_read, s_rvalid, s_busy;
    logic [SMALL_LEN-1:0] s_wdata, s_rdata;
    logic                 s_datum, s_shift, s_xfer, s_dir, s_q;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    pudding_chain_driver #(.CHAIN_LEN(CHAIN_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .chain_datum(chain_datum), .chain_shift(chain_shift),
        .chain_transfer(chain_transfer), .chain_dir(chain_dir), .chain_q(chain_q)
    );

    pudding_chain_driver #(.CHAIN_LEN(SMALL_LEN)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(s_valid), .cmd_ready(s_ready), .cmd_read(s_read),
        .wr_data(s_wdata), .rd_data(s_rdata), .rd_valid(s_rvalid), .busy(s_busy),
        .chain_datum(s_datum), .chain_shift(s_shift),
        .chain_transfer(s_xfer), .chain_dir(s_dir), .chain_q(s_q)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural chains: daisychain + state register, pins sampled at each edge
    logic [CHAIN_LEN-1:0] dc = '0, st = '0;
    logic [SMALL_LEN-1:0] sdc = '0, sst = '0;
    assign chain_q = dc[CHAIN_LEN-1];
    assign s_q     = sdc[SMALL_LEN-1];

    always @(posedge clk) begin
        if (chain_shift) dc <= {dc[CHAIN_LEN-2:0], chain_datum};
        else if (chain_transfer) begin
            if (chain_dir) st <= dc;
            else           dc <= st;
        end
        if (s_shift) sdc <= {sdc[SMALL_LEN-2:0], s_datum};
        else if (s_xfer) begin
            if (s_dir) sst <= sdc;
            else       sdc <= sst;
        end
    end

    function automatic void check_bit(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_word(string name, logic [CHAIN_LEN-1:0] act, logic [CHAIN_LEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: each accepted command expands into a list of expected per-cycle pin states
    typedef struct {
        logic shift; logic xfer; logic dir; logic datum;
        logic rdv; logic commit; logic [CHAIN_LEN-1:0] word;
    } exp_t;

    exp_t                 q[$];
    exp_t                 popped, cur;
    logic [CHAIN_LEN-1:0] exp_state   = '0;
    logic [CHAIN_LEN-1:0] exp_rd_hold = '0;
    int                   n_acc       = 0;
    logic                 idle;

    function automatic exp_t mk(logic sh, logic xf, logic dr, logic dt, logic rv, logic cm,
                                logic [CHAIN_LEN-1:0] w);
        exp_t e;
        e.shift = sh; e.xfer = xf; e.dir = dr; e.datum = dt;
        e.rdv = rv; e.commit = cm; e.word = w;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_rd_hold = '0;
        end else if (q.size() != 0) begin
            popped = q.pop_front();
            if (popped.commit) exp_state   = popped.word;
            if (popped.rdv)    exp_rd_hold = popped.word;
        end else if (cmd_valid) begin
            n_acc++;
            if (cmd_read) begin
                q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
                for (int i = 0; i < CHAIN_LEN; i++)
                    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
                q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_state));
            end else begin
                for (int i = 0; i < CHAIN_LEN; i++)
                    q.push_back(mk(1'b1, 1'b0, 1'b0, wr_data[CHAIN_LEN-1-i], 1'b0, 1'b0, '0));
                q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, wr_data));
            end
        end
    end

    always @(negedge clk) begin
        idle = (q.size() == 0);
        if (!idle) cur = q[0];
        else       cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_bit("cmd_ready", cmd_ready, idle);
        check_bit("busy", busy, !idle);
        check_bit("chain_shift", chain_shift, cur.shift);
        check_bit("chain_transfer", chain_transfer, cur.xfer);
        check_bit("chain_datum", chain_datum, cur.datum);
        check_bit("rd_valid", rd_valid, cur.rdv);
        check_word("rd_data", rd_data, cur.rdv ? cur.word : exp_rd_hold);
        if (cur.xfer) check_bit("chain_dir", chain_dir, cur.dir);
        check_bit("strobe_exclusive", chain_shift && chain_transfer, 1'b0);
    end

    int shift_seen = 0, xfer_seen = 0;
    int rdv_log[$];
    always @(negedge clk) begin
        if (chain_shift)    shift_seen++;
        if (chain_transfer) xfer_seen++;
        if (rd_valid)       rdv_log.push_back(cyc);
    end

    function automatic logic [CHAIN_LEN-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic issue(input logic rd, input logic [CHAIN_LEN-1:0] d, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_read = rd; wr_data = d;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_bit("issue_accepted", ok, 1'b1);
        if (ok) acc = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_data   = rnd();
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q.size() == 0 && cmd_ready) begin ok = 1'b1; break; end
        end
        check_bit("idle_within_budget", ok, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, sh0, xf0, n0, a1, a2, lat, rv;
        logic [CHAIN_LEN-1:0] w1, w2;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; wr_data = '0;
        s_valid = 1'b0; s_read = 1'b0; s_wdata = '0;
        repeat (3) @(negedge clk);
        check_bit("reset_cmd_ready", cmd_ready, 1'b1);
        check_word("reset_rd_data", rd_data, '0);
        check_bit("reset_shift", chain_shift, 1'b0);
        check_bit("reset_dir", chain_dir, 1'b0);
        rst_n = 1'b1;

        // Write MSB-first, then single commit transfer
        sh0 = shift_seen; xf0 = xfer_seen;
        issue(1'b0, c_T2_WORD, acc);
        wait_idle(300);
        check_int("t2_shift_pulses", shift_seen - sh0, CHAIN_LEN);
        check_int("t2_transfer_pulses", xfer_seen - xf0, 1);
        check_word("t2_chain_state", st, c_T2_WORD);
        check_int("t2_uo_out", int'(dc[CHAIN_LEN-1:CHAIN_LEN-8]), 'hA5);

        // Read-back
        issue(1'b0, c_T3_WORD, acc);
        wait_idle(300);
        rdv_log.delete();
        issue(1'b1, rnd(), acc);
        wait_idle(300);
        check_word("t3_rd_data", rd_data, c_T3_WORD);
        check_int("t3_rd_valid_pulses", rdv_log.size(), 1);
        if (rdv_log.size() > 0) check_int("t3_rd_valid_cycle", rdv_log[0] - acc + 1, CHAIN_LEN + 2);
        check_word("t3_daisychain_zero", dc, '0);
        check_word("t3_state_kept", st, c_T3_WORD);

        // Asynchronous reset in the middle of a write shift
        issue(1'b0, rnd(), acc);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        check_bit("t1_pre_reset_shift", chain_shift, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("t1_async_shift", chain_shift, 1'b0);
        check_bit("t1_async_datum", chain_datum, 1'b0);
        check_bit("t1_async_transfer", chain_transfer, 1'b0);
        check_bit("t1_async_dir", chain_dir, 1'b0);
        check_bit("t1_async_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("t1_ready_after", cmd_ready, 1'b1);
        check_word("t1_rd_data_after", rd_data, '0);

        // Back-to-back writes with cmd_valid held high
        w1 = rnd(); w2 = rnd();
        a1 = -1; a2 = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_read = 1'b0; wr_data = w1;
        for (int i = 0; i < 600 && a2 < 0; i++) begin
            if (cmd_ready) begin
                if (a1 < 0) a1 = cyc + 1;
                else        a2 = cyc + 1;
            end else begin
                wr_data = w2;
            end
            if (a2 < 0) @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check_int("t4_accept_gap", a2 - a1, CHAIN_LEN + 2);
        wait_idle(300);
        check_word("t4_final_state", st, w2);

        // Random command traffic
        sh0 = shift_seen; xf0 = xfer_seen; n0 = n_acc;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_read  = 1'($urandom_range(0, 1));
            wr_data   = rnd();
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(400);
        check_int("t5_shifts_per_cmd", shift_seen - sh0, (n_acc - n0) * CHAIN_LEN);
        check_int("t5_transfers_per_cmd", xfer_seen - xf0, n_acc - n0);

        // Short chain instance
        @(negedge clk);
        check_bit("t6_ready", s_ready, 1'b1);
        s_valid = 1'b1; s_read = 1'b0; s_wdata = 8'h81;
        a1 = cyc + 1;
        @(negedge clk);
        s_valid = 1'b0; s_wdata = 8'h00;
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            if (s_ready) begin lat = cyc - a1 + 1; break; end
            @(negedge clk);
        end
        check_int("t6_write_latency", lat, SMALL_LEN + 2);
        check_int("t6_chain_state", int'(sst), 'h81);
        check_bit("t6_ready_read", s_ready, 1'b1);
        s_valid = 1'b1; s_read = 1'b1;
        a1 = cyc + 1;
        @(negedge clk);
        s_valid = 1'b0;
        rv = -1;
        for (int i = 0; i < 50; i++) begin
            if (s_rvalid) begin rv = cyc - a1 + 1; break; end
            @(negedge clk);
        end
        check_int("t6_rd_valid_cycle", rv, SMALL_LEN + 2);
        check_int("t6_rd_data", int'(s_rdata), 'h81);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
